// File: rtl/jk_sequence_driver.sv
// jk_sequence_driver
// Feeds a bank of WIDTH JK flops from a DEPTH-entry command FIFO of target
// words. Each popped target becomes a registered per-bit J/K excitation,
// computed against a shadow copy of the expected flop state. The flop
// outputs are read back two edges after the pop and compared with the
// target. A mismatch sets a sticky flag and bumps a saturating 8-bit
// error counter.
// Build option: define JK_TOGGLE_EN to drive every changing bit with
// J=K=1 (toggle) instead of the set/reset excitation.
module jk_sequence_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_run,
    input  logic                     i_cmd_valid,
    input  logic [WIDTH-1:0]         i_cmd_target,
    output logic                     o_cmd_ready,
    input  logic [WIDTH-1:0]         i_q_fb,
    output logic [WIDTH-1:0]         o_j,
    output logic [WIDTH-1:0]         o_k,
    output logic [WIDTH-1:0]         o_exp_state,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_mismatch,
    output logic [7:0]               o_err_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_exp_state;

    logic             r_p1_v;
    logic [WIDTH-1:0] r_p1_t;
    logic             r_chk_v;
    logic [WIDTH-1:0] r_chk_t;
    logic             r_mismatch;
    logic [7:0]       r_err_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_j_next;
    logic [WIDTH-1:0] w_k_next;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_push = i_cmd_valid && !w_full;
    // Pop decision uses the registered count, so an empty FIFO never bypasses.
    assign w_pop  = i_run && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    assign o_cmd_ready  = !w_full;
    assign o_fifo_count = r_count;
    assign o_j          = r_j;
    assign o_k          = r_k;
    assign o_exp_state  = r_exp_state;
    assign o_mismatch   = r_mismatch;
    assign o_err_count  = r_err_count;

    // Per-bit excitation from the shadow state toward the head target.
    always_comb begin
        w_j_next = '0;
        w_k_next = '0;
`ifdef JK_TOGGLE_EN
        w_j_next = r_exp_state ^ w_head;
        w_k_next = r_exp_state ^ w_head;
`else
        w_j_next = ~r_exp_state & w_head;
        w_k_next = r_exp_state & ~w_head;
`endif
    end

    // FIFO storage write; contents need no reset since the count gates reads.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd_target;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2**AW.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // J/K drive and shadow state; any edge without a pop drives hold.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_j         <= '0;
            r_k         <= '0;
            r_exp_state <= '0;
        end else if (w_pop) begin
            r_j         <= w_j_next;
            r_k         <= w_k_next;
            r_exp_state <= w_head;
        end else begin
            r_j <= '0;
            r_k <= '0;
        end
    end

    // Readback check: target travels two stages so the compare lines up
    // with q_fb after the bank has sampled the drive.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_p1_v      <= 1'b0;
            r_p1_t      <= '0;
            r_chk_v     <= 1'b0;
            r_chk_t     <= '0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_p1_v  <= w_pop;
            r_p1_t  <= w_head;
            r_chk_v <= r_p1_v;
            r_chk_t <= r_p1_t;
            if (r_chk_v && (i_q_fb != r_chk_t)) begin
                r_mismatch <= 1'b1;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_sequence_driver.sv
// Testbench for jk_sequence_driver: a behavioural JK bank closes the loop,
// a queue-based reference model predicts every output after each edge,
// and a negedge monitor pops and compares those predictions.
`timescale 1ns/1ps
module tb_jk_sequence_driver;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  target = '0;
    logic [W-1:0]  stuck = '0;
    logic [W-1:0]  bank_q = '0;
    logic [W-1:0]  q_fb;
    logic          rdy;
    logic [W-1:0]  j, k, es;
    logic [CW-1:0] cnt;
    logic          mis;
    logic [7:0]    ec;

    int checks = 0;
    int errors = 0;
    logic drain_fail = 1'b0;

    always #5 clk = ~clk;

    jk_sequence_driver #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_run        (run),
        .i_cmd_valid  (valid),
        .i_cmd_target (target),
        .o_cmd_ready  (rdy),
        .i_q_fb       (q_fb),
        .o_j          (j),
        .o_k          (k),
        .o_exp_state  (es),
        .o_fifo_count (cnt),
        .o_mismatch   (mis),
        .o_err_count  (ec)
    );

    // JK flop bank, reset together with the driver; stuck bits force q_fb low.
    always @(posedge clk) begin
        if (rst) bank_q <= '0;
        else begin
            for (int unsigned b = 0; b < W; b++) begin
                case ({j[b], k[b]})
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
            end
        end
    end
    assign q_fb = bank_q & ~stuck;

    typedef struct packed {
        logic [W-1:0]  j, k, es, q;
        logic [CW-1:0] cnt;
        logic          rdy, mis;
        logic [7:0]    ec;
    } exp_t;

    typedef struct {
        int           due;
        logic [W-1:0] t;
    } pend_t;

    exp_t         sb[$];
    logic [W-1:0] mfifo[$];
    pend_t        pend[$];
    pend_t        np[$];
    int           cyc = 0;
    logic [W-1:0] m_es = '0, m_j = '0, m_k = '0, m_q = '0, m_t;
    logic         m_mis = 1'b0;
    int           m_err = 0;
    logic         dpop, dpush;
    exp_t         e_new;

    // Reference model: FIFO as a queue, each pop schedules the flop update
    // one edge later and the readback check two edges later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mfifo.delete();
            pend.delete();
            m_es = '0; m_j = '0; m_k = '0; m_q = '0;
            m_mis = 1'b0; m_err = 0;
        end else begin
            dpop  = run && (mfifo.size() > 0);
            dpush = valid && (mfifo.size() < D);
            np.delete();
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if ((pend[i].t & ~stuck) != pend[i].t) begin
                        m_mis = 1'b1;
                        if (m_err < 255) m_err++;
                    end
                end else begin
                    if (pend[i].due == cyc + 1) m_q = pend[i].t;
                    np.push_back(pend[i]);
                end
            end
            pend = np;
            if (dpop) begin
                m_t = mfifo.pop_front();
                for (int unsigned b = 0; b < W; b++) begin
`ifdef JK_TOGGLE_EN
                    m_j[b] = (m_es[b] != m_t[b]);
                    m_k[b] = (m_es[b] != m_t[b]);
`else
                    m_j[b] = !m_es[b] && m_t[b];
                    m_k[b] = m_es[b] && !m_t[b];
`endif
                end
                m_es = m_t;
                pend.push_back('{due: cyc + 2, t: m_t});
            end else begin
                m_j = '0;
                m_k = '0;
            end
            if (dpush) mfifo.push_back(target);
        end
        e_new.j   = m_j;
        e_new.k   = m_k;
        e_new.es  = m_es;
        e_new.q   = m_q;
        e_new.cnt = CW'(mfifo.size());
        e_new.rdy = (mfifo.size() < D);
        e_new.mis = m_mis;
        e_new.ec  = 8'(m_err);
        sb.push_back(e_new);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    exp_t e_chk;
    // Monitor: compares DUT outputs with the oldest prediction, mid-cycle.
    always @(negedge clk) begin
        if (drain_fail) begin
            checks++;
            errors++;
            $display("FAIL drain: scoreboard left %0d entries, expected 0", sb.size());
            drain_fail = 1'b0;
        end
        if (sb.size() > 0) begin
            e_chk = sb.pop_front();
            cmp("j",          32'(j),    32'(e_chk.j));
            cmp("k",          32'(k),    32'(e_chk.k));
            cmp("exp_state",  32'(es),   32'(e_chk.es));
            cmp("fifo_count", 32'(cnt),  32'(e_chk.cnt));
            cmp("cmd_ready",  32'(rdy),  32'(e_chk.rdy));
            cmp("mismatch",   32'(mis),  32'(e_chk.mis));
            cmp("err_count",  32'(ec),   32'(e_chk.ec));
            cmp("q_fb",       32'(q_fb), 32'(e_chk.q & ~stuck));
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] t, input logic r, input logic rs);
        valid  = v;
        target = t;
        run    = r;
        rst    = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, r, 1'b0);
    endtask

    initial begin
        // Single target 4'hA
        drive(0, '0, 1, 1);
        drive(0, '0, 1, 1);
        drive(1, 4'hA, 1, 0);
        idle(1, 4);

        // Fill while held, overflow word 5 refused, then drain
        drive(0, '0, 0, 1);
        for (int unsigned v = 1; v <= 5; v++) drive(1, W'(v), 0, 0);
        idle(0, 2);
        idle(1, 6);

        // All ones to all zeros
        drive(1, 4'hF, 1, 0);
        drive(1, 4'h0, 1, 0);
        idle(1, 4);

        // Bit0 stuck low: both checks fail
        stuck = 4'h1;
        drive(1, 4'h1, 1, 0);
        drive(1, 4'h3, 1, 0);
        idle(1, 5);
        stuck = '0;
        idle(1, 2);

        // Reset one cycle after the pop drops the pending check
        drive(0, '0, 1, 1);
        drive(1, 4'h6, 1, 0);
        idle(1, 1);
        drive(0, '0, 1, 1);
        idle(1, 5);

        // Simultaneous push/pop at count 2, wrapping pointers
        drive(1, 4'h9, 0, 0);
        drive(1, 4'hC, 0, 0);
        for (int i = 0; i < 3 * D; i++) drive(1, W'($urandom), 1, 0);
        idle(1, 5);

        // Randomized traffic with occasional reset and stuck faults
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 40) stuck = W'($urandom);
            if (i % 80 == 60) stuck = '0;
            drive(($urandom_range(0, 2) != 0), W'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        end
        stuck = '0;
        idle(1, 8);

        @(negedge clk);
        #1;
        if (sb.size() != 0) drain_fail = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
